// File: rtl/data_path_pipe.sv
// data_path_pipe
//   Pipelined register-file / ALU datapath. Instructions enter on an
//   in_valid/in_ready handshake, are evaluated combinationally against the
//   register file and captured into a single registered execute (EX) stage.
//   The EX result leaves on an out_valid/out_ready handshake; the register
//   write-back and the architectural flag update happen when it retires.
//
//   Optional feature macro: DATA_PATH_FWD_EN
//     defined   : the EX result is forwarded to dependent operands, so a
//                 dependent instruction can issue on the very next cycle.
//     undefined : no forwarding; a dependent instruction is held off
//                 (in_ready=0) until its producer has retired.
//
//   Flags are {C,L,F,Z,N} on bits 4..0.
module data_path_pipe #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        opcode,
  input  logic [REG_AW-1:0] rdest_select,
  input  logic [REG_AW-1:0] rsrc_select,
  input  logic              imm_select,
  input  logic [DATA_W-1:0] imm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        flags_out,
  input  logic [REG_AW-1:0] dbg_select,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int MSB = DATA_W - 1;

  // Instruction encodings; every other opcode value behaves as a NOP.
  typedef enum logic [7:0] {
    OP_AND = 8'h01,
    OP_OR  = 8'h02,
    OP_XOR = 8'h03,
    OP_LSH = 8'h04,
    OP_ADD = 8'h05,
    OP_SUB = 8'h09,
    OP_CMP = 8'h0B,
    OP_MOV = 8'h0D
  } opcode_e;

  // Bit order matches flags_out: C is bit 4, N is bit 0.
  typedef struct packed {
    logic c;  // carry / borrow
    logic l;  // unsigned less-than
    logic f;  // signed overflow
    logic z;  // zero
    logic n;  // negative
  } flags_t;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [NUM_REGS];
  flags_t            arch_flags;

  // EX stage
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic              ex_we;
  logic [REG_AW-1:0] ex_dest;
  flags_t            ex_flags;
  logic              ex_upd;

  // Handshake events
  logic accept;
  logic retire;

  // ---------------------------------------------------------------------------
  // Operand fetch, with optional EX forwarding
  // ---------------------------------------------------------------------------
  logic              fwd_a;
  logic              fwd_b;
  logic              stall_hazard;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

`ifdef DATA_PATH_FWD_EN
  // The EX result is the newest value of its destination register, whether or
  // not it retires this cycle, so dependent operands take it directly.
  assign fwd_a        = ex_valid && ex_we && (ex_dest == rdest_select);
  assign fwd_b        = ex_valid && ex_we && imm_select && (ex_dest == rsrc_select);
  assign stall_hazard = 1'b0;
`else
  // Without forwarding the register file is stale while a write is pending,
  // so any instruction reading the pending destination must wait.
  assign fwd_a        = 1'b0;
  assign fwd_b        = 1'b0;
  assign stall_hazard = ex_valid && ex_we &&
                        ((ex_dest == rdest_select) ||
                         (imm_select && (ex_dest == rsrc_select)));
`endif

  assign op_a = fwd_a ? ex_result : regs[rdest_select];
  assign op_b = !imm_select ? imm_in :
                fwd_b       ? ex_result : regs[rsrc_select];

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // EX can take a new instruction when empty or when it is draining this cycle.
  assign in_ready = (!ex_valid || out_ready) && !stall_hazard;
  assign accept   = in_valid && in_ready;
  assign retire   = ex_valid && out_ready;

  assign out_valid = ex_valid;
  assign result    = ex_result;
  assign flags_out = arch_flags;
  assign dbg_data  = regs[dbg_select];

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   add_full;
  logic [DATA_W:0]   sub_full;
  logic [DATA_W-1:0] lsh_val;
  logic              add_ovf;
  logic              sub_ovf;
  logic              signed_lt;

  // The extra top bit of the widened add/subtract is the carry/borrow.
  assign add_full  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full  = {1'b0, op_a} - {1'b0, op_b};
  assign add_ovf   = (op_a[MSB] == op_b[MSB]) && (add_full[MSB] != op_a[MSB]);
  assign sub_ovf   = (op_a[MSB] != op_b[MSB]) && (sub_full[MSB] != op_a[MSB]);
  assign signed_lt = $signed(op_a) < $signed(op_b);
  // B[4] selects direction, B[3:0] is the distance; right shifts are logical.
  assign lsh_val   = op_b[4] ? (op_a >> op_b[3:0]) : (op_a << op_b[3:0]);

  logic [DATA_W-1:0] alu_result;
  flags_t            alu_flags;
  logic              alu_we;
  logic              alu_upd;
  logic              alu_zn;

  // Decode the opcode into result, write-enable and the new flag set.
  always_comb begin
    // NOTE: every output of this block is assigned a default before the case;
    // a path that skipped one would infer a latch.
    alu_result = '0;
    alu_flags  = '0;
    alu_we     = 1'b0;
    alu_upd    = 1'b0;
    alu_zn     = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_result  = add_full[MSB:0];
        alu_flags.c = add_full[DATA_W];
        alu_flags.f = add_ovf;
        alu_we      = 1'b1;
        alu_upd     = 1'b1;
        alu_zn      = 1'b1;
      end
      OP_SUB: begin
        alu_result  = sub_full[MSB:0];
        alu_flags.c = sub_full[DATA_W];
        alu_flags.l = sub_full[DATA_W];
        alu_flags.f = sub_ovf;
        alu_we      = 1'b1;
        alu_upd     = 1'b1;
        alu_zn      = 1'b1;
      end
      OP_CMP: begin
        // Same subtraction, but flags describe the comparison, not the result.
        alu_result  = sub_full[MSB:0];
        alu_flags.c = sub_full[DATA_W];
        alu_flags.l = sub_full[DATA_W];
        alu_flags.z = (op_a == op_b);
        alu_flags.n = signed_lt;
        alu_upd     = 1'b1;
      end
      OP_AND: begin
        alu_result = op_a & op_b;
        alu_we     = 1'b1;
        alu_upd    = 1'b1;
        alu_zn     = 1'b1;
      end
      OP_OR: begin
        alu_result = op_a | op_b;
        alu_we     = 1'b1;
        alu_upd    = 1'b1;
        alu_zn     = 1'b1;
      end
      OP_XOR: begin
        alu_result = op_a ^ op_b;
        alu_we     = 1'b1;
        alu_upd    = 1'b1;
        alu_zn     = 1'b1;
      end
      OP_MOV: begin
        alu_result = op_b;
        alu_we     = 1'b1;
        alu_upd    = 1'b1;
        alu_zn     = 1'b1;
      end
      OP_LSH: begin
        alu_result = lsh_val;
        alu_we     = 1'b1;
        alu_upd    = 1'b1;
        alu_zn     = 1'b1;
      end
      default: begin
        // NOP: travels through EX with no architectural effect.
      end
    endcase
    if (alu_zn) begin
      alu_flags.z = (alu_result == '0);
      alu_flags.n = alu_result[MSB];
    end
  end

  // ---------------------------------------------------------------------------
  // EX stage register: refill on accept, otherwise empty on retire
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_result <= '0;
      ex_we     <= 1'b0;
      ex_dest   <= '0;
      ex_flags  <= '0;
      ex_upd    <= 1'b0;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      ex_result <= alu_result;
      ex_we     <= alu_we;
      ex_dest   <= rdest_select;
      ex_flags  <= alu_flags;
      ex_upd    <= alu_upd;
    end else if (retire) begin
      ex_valid  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file write-back at retirement
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register file is architectural state that must read as zero
      // after reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (retire && ex_we) begin
      regs[ex_dest] <= ex_result;
    end
  end

  // Architectural flags follow retirement only; they are never forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arch_flags <= '0;
    end else if (retire && ex_upd) begin
      arch_flags <= ex_flags;
    end
  end

endmodule

// File: tb/tb_data_path_pipe.sv
// tb_data_path_pipe
//   Self-checking bench for data_path_pipe. A behavioural model executes each
//   accepted instruction in program order with plain integer arithmetic and
//   keeps a separate architectural copy updated at retirement. Every cycle the
//   bench compares in_ready, out_valid, result, flags_out and a random
//   dbg_data read against the model. Compile with the same DATA_PATH_FWD_EN
//   setting as the design.
module tb_data_path_pipe;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        opcode;
  logic [REG_AW-1:0] rdest_select;
  logic [REG_AW-1:0] rsrc_select;
  logic              imm_select;
  logic [DATA_W-1:0] imm_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [4:0]        flags_out;
  logic [REG_AW-1:0] dbg_select;
  logic [DATA_W-1:0] dbg_data;

  always #5 clk = ~clk;

  data_path_pipe #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .REG_AW  (REG_AW)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .rdest_select(rdest_select),
    .rsrc_select (rsrc_select),
    .imm_select  (imm_select),
    .imm_in      (imm_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags_out   (flags_out),
    .dbg_select  (dbg_select),
    .dbg_data    (dbg_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: program-order register view, retired register view, flags.
  int unsigned spec_regs [NUM_REGS];
  int unsigned arch_regs [NUM_REGS];
  logic [4:0]  arch_flags;

  typedef struct {
    bit          valid;
    bit          known;
    int unsigned res;
    bit          we;
    int          dest;
    bit          upd;
    logic [4:0]  flags;
  } pend_t;

  pend_t pend;

  // Observations from the most recent step.
  bit          last_acc;
  bit          obs_ready;
  bit          obs_valid;
  int unsigned obs_result;
  int unsigned last_ret_result;

  // Instruction semantics from the opcode table, in plain integer arithmetic.
  function automatic void model_op(input logic [7:0] op, input int unsigned a,
                                   input int unsigned b, output int unsigned res,
                                   output bit we, output bit upd, output bit known,
                                   output logic [4:0] fl);
    int sa, sb, s;
    int unsigned sh;
    bit c, l, f, z, n;
    c = 0; l = 0; f = 0; z = 0; n = 0;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    res = 0; we = 1; upd = 1; known = 1;
    case (op)
      8'h05: begin
        res = (a + b) % 65536;
        c   = (a + b) > 65535;
        s   = sa + sb;
        f   = (s > 32767) || (s < -32768);
      end
      8'h09: begin
        res = (a + 65536 - b) % 65536;
        c   = a < b;
        l   = a < b;
        s   = sa - sb;
        f   = (s > 32767) || (s < -32768);
      end
      8'h0B: begin
        res = (a + 65536 - b) % 65536;
        we  = 0;
        c   = a < b;
        l   = a < b;
        z   = (a == b);
        n   = (sa < sb);
      end
      8'h01: res = a & b;
      8'h02: res = a | b;
      8'h03: res = a ^ b;
      8'h0D: res = b;
      8'h04: begin
        sh = b % 16;
        if (((b / 16) % 2) == 1) res = a >> sh;
        else                     res = (a << sh) % 65536;
      end
      default: begin
        we = 0; upd = 0; known = 0;
      end
    endcase
    if (op != 8'h0B) begin
      z = (res == 0);
      n = (res >= 32768);
    end
    fl = {c, l, f, z, n};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      spec_regs[i] = 0;
      arch_regs[i] = 0;
    end
    arch_flags = 5'd0;
    pend.valid = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare 1 time unit later,
  // advance the model across the rising edge.
  task automatic step(input bit iv, input logic [7:0] op, input int rd, input int rs,
                      input bit isel, input int unsigned imm, input bit ordy);
    bit          exp_ready, acc, ret;
    int          dsel;
    int unsigned a, b, res;
    bit          we, upd, known;
    logic [4:0]  fl;
    pend_t       np;
    in_valid     = iv;
    opcode       = op;
    rdest_select = REG_AW'(rd);
    rsrc_select  = REG_AW'(rs);
    imm_select   = isel;
    imm_in       = DATA_W'(imm);
    out_ready    = ordy;
    dsel         = int'($urandom_range(0, NUM_REGS - 1));
    dbg_select   = REG_AW'(dsel);
    #1;
    exp_ready = !pend.valid || ordy;
`ifndef DATA_PATH_FWD_EN
    if (pend.valid && pend.we && (pend.dest == rd || (isel && pend.dest == rs)))
      exp_ready = 0;
`endif
    n_checks++;
    if (in_ready !== exp_ready)
      $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== pend.valid)
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, pend.valid);
    else n_pass++;
    if (pend.valid && pend.known) begin
      n_checks++;
      if (result !== DATA_W'(pend.res))
        $display("FAIL result @%0t: got %h expected %h", $time, result, DATA_W'(pend.res));
      else n_pass++;
    end
    n_checks++;
    if (flags_out !== arch_flags)
      $display("FAIL flags_out @%0t: got %b expected %b", $time, flags_out, arch_flags);
    else n_pass++;
    n_checks++;
    if (dbg_data !== DATA_W'(arch_regs[dsel]))
      $display("FAIL dbg_data r%0d @%0t: got %h expected %h", dsel, $time, dbg_data,
               DATA_W'(arch_regs[dsel]));
    else n_pass++;
    obs_ready  = in_ready;
    obs_valid  = out_valid;
    obs_result = result;

    ret = pend.valid && ordy;
    acc = iv && exp_ready;
    np  = pend;
    if (acc) begin
      a = spec_regs[rd];
      b = isel ? spec_regs[rs] : (imm % 65536);
      model_op(op, a, b, res, we, upd, known, fl);
      np.valid = 1; np.known = known; np.res = res; np.we = we;
      np.dest = rd; np.upd = upd; np.flags = fl;
      if (we) spec_regs[rd] = res;
    end
    last_acc = acc;
    @(posedge clk);
    if (ret) begin
      if (pend.we)  arch_regs[pend.dest] = pend.res;
      if (pend.upd) arch_flags = pend.flags;
      last_ret_result = pend.res;
    end
    if (acc)      pend = np;
    else if (ret) pend.valid = 0;
    @(negedge clk);
  endtask

  // Keep offering one instruction until it is accepted (bounded).
  task automatic issue(input logic [7:0] op, input int rd, input int rs, input bit isel,
                       input int unsigned imm);
    int tries = 0;
    do begin
      step(1, op, rd, rs, isel, imm, 1);
      tries++;
    end while (!last_acc && tries < 10);
    n_checks++;
    if (!last_acc) $display("FAIL issue_timeout: op %h not accepted in %0d cycles", op, tries);
    else n_pass++;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && pend.valid; i++) step(0, 8'h00, 0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL drain_timeout: out_valid got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic read_reg(input int idx, output logic [DATA_W-1:0] v);
    dbg_select = REG_AW'(idx);
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] v;
    rst_n = 1'b0;
    in_valid = 0; opcode = 0; rdest_select = 0; rsrc_select = 0;
    imm_select = 0; imm_in = 0; out_ready = 0; dbg_select = 0;
    model_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (result !== '0) $display("FAIL reset_result: got %h expected 0", result);
    else n_pass++;
    n_checks++;
    if (flags_out !== 5'd0) $display("FAIL reset_flags: got %b expected 0", flags_out);
    else n_pass++;
    for (int i = 0; i < NUM_REGS; i++) begin
      read_reg(i, v);
      n_checks++;
      if (v !== '0) $display("FAIL reset_reg r%0d: got %h expected 0", i, v);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mov();
    logic [DATA_W-1:0] v;
    step(1, 8'h0D, 3, 0, 0, 32'h1234, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    n_checks++;
    if (!obs_valid || obs_result != 32'h1234)
      $display("FAIL mov_result: got valid=%b %h expected valid=1 1234", obs_valid, obs_result);
    else n_pass++;
    read_reg(3, v);
    n_checks++;
    if (v !== 16'h1234) $display("FAIL mov_r3: got %h expected 1234", v);
    else n_pass++;
    n_checks++;
    if (flags_out[1:0] !== 2'b00) $display("FAIL mov_zn: got %b expected 00", flags_out[1:0]);
    else n_pass++;
  endtask

  task automatic test_add_flags();
    issue(8'h0D, 1, 0, 0, 32'hFFFF);
    issue(8'h05, 1, 0, 0, 1);
    drain();
    n_checks++;
    if (last_ret_result != 0 || flags_out !== 5'b10010)
      $display("FAIL add_carry: got %h flags %b expected 0000 flags 10010",
               last_ret_result, flags_out);
    else n_pass++;
    issue(8'h0D, 2, 0, 0, 32'h7FFF);
    issue(8'h05, 2, 0, 0, 1);
    drain();
    n_checks++;
    if (last_ret_result != 32'h8000 || flags_out !== 5'b00101)
      $display("FAIL add_overflow: got %h flags %b expected 8000 flags 00101",
               last_ret_result, flags_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    bit exp_b2b;
    int tries;
`ifdef DATA_PATH_FWD_EN
    exp_b2b = 1;
`else
    exp_b2b = 0;
`endif
    drain();
    step(1, 8'h0D, 4, 0, 0, 5, 1);
    step(1, 8'h05, 4, 4, 1, 0, 1);
    n_checks++;
    if (obs_ready !== exp_b2b)
      $display("FAIL b2b_in_ready: got %b expected %b", obs_ready, exp_b2b);
    else n_pass++;
    tries = 0;
    while (!last_acc && tries < 5) begin
      step(1, 8'h05, 4, 4, 1, 0, 1);
      tries++;
    end
    n_checks++;
    if (tries != (exp_b2b ? 0 : 1))
      $display("FAIL b2b_bubbles: got %0d expected %0d", tries, exp_b2b ? 0 : 1);
    else n_pass++;
    drain();
    read_reg(4, v);
    n_checks++;
    if (last_ret_result != 10 || v !== 16'd10)
      $display("FAIL b2b_result: got %0d r4=%0d expected 10", last_ret_result, v);
    else n_pass++;
  endtask

  task automatic test_cmp();
    logic [DATA_W-1:0] v;
    issue(8'h0D, 5, 0, 0, 3);
    issue(8'h0B, 5, 0, 0, 32'hFFFF);
    drain();
    read_reg(5, v);
    n_checks++;
    if (v !== 16'd3) $display("FAIL cmp_no_write: got r5=%h expected 0003", v);
    else n_pass++;
    n_checks++;
    if (flags_out !== 5'b11000) $display("FAIL cmp_flags: got %b expected 11000", flags_out);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] v;
    drain();
    step(1, 8'h0D, 6, 0, 0, 32'h00AA, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h0D, 8, 0, 0, 32'h0055, 0);
      n_checks++;
      if (obs_ready !== 1'b0 || obs_result != 32'h00AA)
        $display("FAIL hold_%0d: got ready=%b result=%h expected ready=0 result=00aa",
                 i, obs_ready, obs_result);
      else n_pass++;
      read_reg(6, v);
      n_checks++;
      if (v !== 16'h0000) $display("FAIL hold_r6_%0d: got %h expected 0000", i, v);
      else n_pass++;
    end
    step(1, 8'h0D, 8, 0, 0, 32'h0055, 1);
    n_checks++;
    if (obs_ready !== 1'b1 || !last_acc)
      $display("FAIL release_accept: got ready=%b expected 1", obs_ready);
    else n_pass++;
    drain();
    read_reg(6, v);
    n_checks++;
    if (v !== 16'h00AA) $display("FAIL release_r6: got %h expected 00aa", v);
    else n_pass++;
    read_reg(8, v);
    n_checks++;
    if (v !== 16'h0055) $display("FAIL release_r8: got %h expected 0055", v);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] ops [9];
    logic [7:0] op;
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h09, 8'h0B, 8'h0D, 8'h00};
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 8)];
      if (op == 8'h00) op = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 65535), $urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] v;
    drain();
    step(1, 8'h0D, 7, 0, 0, 32'hBEEF, 0);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(7, v);
    n_checks++;
    if (v !== '0) $display("FAIL midreset_r7: got %h expected 0000", v);
    else n_pass++;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_mov();
    test_add_flags();
    test_back_to_back();
    test_cmp();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_path_pipe.md
Name: data_path_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle register-bank/ALU datapath.
- Contains an NUM_REGS x DATA_W register file, Rdest/Rsrc read muxes, an immediate-or-register operand select, and an ALU with a registered execute (EX) stage.
- Instructions arrive on a valid/ready handshake. Results leave on a second valid/ready handshake. Register write-back and the flag update happen at output retirement.
- EX-stage results are forwarded to dependent instructions.

Parameters:
- DATA_W, 16, datapath width; must be >= 16.
- NUM_REGS, 16, number of general registers; power of two, >= 2.
- REG_AW, 4, register select width; must equal log2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- opcode  in  8  ALU operation.
- rdest_select  in  REG_AW  destination and first-operand register.
- rsrc_select  in  REG_AW  source register.
- imm_select  in  1  0 = operand B is imm_in; 1 = operand B is Rsrc.
- imm_in  in  DATA_W  immediate operand.
- out_valid  out  1  EX stage holds a result.
- out_ready  in  1  downstream accepts the result.
- result  out  DATA_W  EX result.
- flags_out  out  5  architectural flags {C,L,F,Z,N}, bits 4..0.
- dbg_select  in  REG_AW  debug read select.
- dbg_data  out  DATA_W  combinational register-file read; not forwarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0.
  - EX valid, result and flags_out cleared to 0.
  - in_ready is 1 once reset=1.
- Operands:
  - A = Rdest.
  - B = imm_in or Rsrc, per imm_select.
  - Both operands are read after forwarding.
- Opcodes. Any other value is a NOP: it passes through EX, writes nothing and leaves the flags unchanged.
  - ADD 8'h05: A+B. C = carry out, F = signed overflow, L = 0.
  - SUB 8'h09: A-B. C = L = borrow (A<B unsigned), F = signed overflow.
  - CMP 8'h0B: computes A-B with no register write. C = L = (A<B unsigned), F = 0, Z = (A==B), N = (A<B signed).
  - AND 8'h01, OR 8'h02, XOR 8'h03, MOV 8'h0D (result = B): C = F = L = 0.
  - LSH 8'h04: if B[4]==0, A << B[3:0]; else A >> B[3:0] logical. C = F = L = 0.
  - For every op except CMP: Z = (result==0), N = result MSB.
- Writes: every valid op except CMP and NOP writes Rdest.
- Pipeline:
  - Accept captures the result, write-enable, destination, new flags and an updates-flags bit into EX; out_valid=1 on the next cycle (latency 1).
  - in_ready = !out_valid || out_ready. Accept and retire may occur in the same cycle, giving throughput 1/cycle.
  - On retire (out_valid && out_ready): the register write occurs if enabled, flags_out updates if the op updates flags, and EX then empties or refills.
  - With out_ready=0, EX holds result and flags stable, and in_ready=0.
- Forwarding:
  - Condition: out_valid && EX write-enable && EX dest == select.
  - When true, the operand uses the EX result instead of the register file. This applies to rdest_select and to rsrc_select (rsrc only when imm_select=1).
  - This holds whether or not EX retires in the same cycle.
- Flag forwarding is not provided: flags_out is architectural (post-retire).
- Reset mid-operation discards the EX contents; no write occurs.

Optional Feature:
- Macro: DATA_PATH_FWD_EN.
- Defined: forwarding exactly as described under Behaviour.
- Undefined: no forwarding paths. in_ready is additionally forced to 0 when out_valid && EX write-enable && (EX dest == rdest_select || (imm_select && EX dest == rsrc_select)). The instruction is accepted the cycle after the hazard retires. Results are identical; only timing changes.

Test Plan:
- Reset, then MOV r3 <- imm 16'h1234 with out_ready=1 -> out_valid one cycle later with result 16'h1234, dbg_data(r3)=16'h1234 after retire, flags Z=0, N=0.
- r1=16'hFFFF, ADD r1, imm 16'h0001 -> result 0, C=1, Z=1, F=0, N=0.
- r2=16'h7FFF, ADD r2, imm 1 -> result 16'h8000, F=1, N=1, C=0.
- Back-to-back MOV r4<-5 then ADD r4, r4 (imm_select=1) on consecutive cycles -> result 10. With DATA_PATH_FWD_EN: no bubble. Without it: in_ready=0 for one cycle.
- CMP r5=3 vs imm 16'hFFFF -> no register write; L=1, C=1, N=0 (3 > -1 signed), Z=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stable, r unchanged. Then out_ready=1 -> retire, and the next instruction is accepted in the same cycle.
